// File: rtl/inv_shift_row.sv
// AES decrypt InvShiftRows stage feeding a small ready/valid output FIFO.
// Latency: one clock; a block pushed at edge N shows on data_out after edge N when the FIFO was empty.
// Backpressure: ready_out is decoded from registered occupancy only; a full FIFO refuses pushes even if a pop happens that cycle.
//
// Ports:
//   clk, rst                       rising-edge clock, asynchronous active-low reset
//   invShiftRow_valid_in/ready_out upstream handshake, data_in is the state block
//   invShiftRow_valid_out/ready_in downstream handshake, data_out is the FIFO head
//   invShiftRow_count              FIFO occupancy (0..DEPTH)

// Generic synchronous FIFO with occupancy counter.
// Latency: one clock from push to head visibility.
// Backpressure: push_rdy drops when full; pop only when pop_vld.
module isr_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Both flags come straight from the count register, so neither handshake
  // side sees a combinational path from the other.
  assign push_rdy = (count != CW'(DEPTH));
  assign pop_vld  = (count != '0);
  assign push     = push_vld & push_rdy;
  assign pop      = pop_vld & pop_rdy;
  assign pop_dat  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Storage is cleared so the head reads zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// AES InvShiftRows with registered output FIFO.
// Latency: one clock into an empty FIFO.
// Backpressure: holds data_out/valid_out while ready_in is low; ready_out low when full.
module inv_shift_row #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         invShiftRow_valid_in,
  output logic                         invShiftRow_ready_out,
  input  logic [DATA_WIDTH-1:0]        invShiftRow_data_in,
  output logic [DATA_WIDTH-1:0]        invShiftRow_data_out,
  output logic                         invShiftRow_valid_out,
  input  logic                         invShiftRow_ready_in,
  output logic [$clog2(DEPTH+1)-1:0]   invShiftRow_count
);

  if (DATA_WIDTH != 128) begin : g_bad_width
    $error("inv_shift_row: DATA_WIDTH must be 128");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("inv_shift_row: DEPTH must be a power of two and at least 2");
  end

  // Source byte for each output byte. Bytes are numbered b = 4*col + row with
  // byte 0 in the top bits; row r is rotated right by r columns.
  localparam int SRC [16] = '{ 0, 13, 10,  7,
                               4,  1, 14, 11,
                               8,  5,  2, 15,
                              12,  9,  6,  3};

  function automatic logic [DATA_WIDTH-1:0] inv_shift(input logic [DATA_WIDTH-1:0] blk);
    logic [DATA_WIDTH-1:0] res;
    res = '0;
    for (int b = 0; b < 16; b++) begin
      res[DATA_WIDTH-1-8*b -: 8] = blk[DATA_WIDTH-1-8*SRC[b] -: 8];
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] xf_dat;

  // The FIFO stores already-transformed blocks, so the head needs no logic.
  assign xf_dat = inv_shift(invShiftRow_data_in);

  isr_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (invShiftRow_valid_in),
    .push_rdy (invShiftRow_ready_out),
    .push_dat (xf_dat),
    .pop_vld  (invShiftRow_valid_out),
    .pop_rdy  (invShiftRow_ready_in),
    .pop_dat  (invShiftRow_data_out),
    .count    (invShiftRow_count)
  );

endmodule

// File: tb/tb_inv_shift_row.sv
module tb_inv_shift_row;

  logic         clk;
  logic         rst;
  logic         valid_in;
  logic         ready_out;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic         valid_out;
  logic         ready_in;
  logic [1:0]   count;

  int checks;
  int errors;

  inv_shift_row #(.DATA_WIDTH(128), .DEPTH(2)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .invShiftRow_valid_in  (valid_in),
    .invShiftRow_ready_out (ready_out),
    .invShiftRow_data_in   (data_in),
    .invShiftRow_data_out  (data_out),
    .invShiftRow_valid_out (valid_out),
    .invShiftRow_ready_in  (ready_in),
    .invShiftRow_count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  // Reference: state as a 4x4 row/col grid, out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [127:0] ref_inv(input logic [127:0] blk);
    logic [7:0] st [4][4];
    logic [127:0] res;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = blk[127 - 8*(4*c + r) -: 8];
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127 - 8*(4*c + r) -: 8] = st[r][(c - r + 4) % 4];
    return res;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [6];
  logic [127:0] blk_a, blk_b, blk_c;
  logic [127:0] q [$];
  int sent, got;
  logic push_ok, pop_ok;

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    data_in  = '0;

    vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h000d0a0704010e0b0805020f0c090603};
    vecs[1] = '{128'h0055aaff4499ee3388dd2277cc1166bb, 128'h00112233445566778899aabbccddeeff};
    vecs[2] = '{128'h11223344000000000000000000000000, 128'h11000000002200000000330000000044};
    vecs[3] = '{128'h000000000000000000000000aabbccdd, 128'h00bb00000000cc00000000ddaa000000};
    vecs[4] = '{128'hffffffffffffffffffffffffffffffff, 128'hffffffffffffffffffffffffffffffff};
    vecs[5] = '{128'h00000000000000000000000000ff0000, 128'h00ff0000000000000000000000000000};

    // Reset state.
    #12;
    chk("rst_valid_out", 128'(valid_out), 128'd0);
    chk("rst_ready_out", 128'(ready_out), 128'd1);
    chk("rst_count",     128'(count),     128'd0);
    chk("rst_data_out",  data_out,        128'd0);
    step();
    rst = 1'b1;

    // Table: one block in, visible next cycle for exactly one cycle.
    ready_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      valid_in = 1'b1;
      data_in  = vecs[i].din;
      step();
      valid_in = 1'b0;
      data_in  = '0;
      chk($sformatf("vec%0d_valid", i), 128'(valid_out), 128'd1);
      chk($sformatf("vec%0d_data", i),  data_out,        vecs[i].exp);
      chk($sformatf("vec%0d_count", i), 128'(count),     128'd1);
      step();
      chk($sformatf("vec%0d_drain", i), 128'(valid_out), 128'd0);
    end

    // Back-pressure: A, B accepted, C held while full.
    blk_a = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
    blk_b = 128'hb0b1b2b3b4b5b6b7b8b9babbbcbdbebf;
    blk_c = 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf;
    ready_in = 1'b0;
    valid_in = 1'b1;
    data_in  = blk_a;
    step();
    chk("bp_count_a", 128'(count), 128'd1);
    data_in = blk_b;
    step();
    chk("bp_count_b", 128'(count), 128'd2);
    chk("bp_ready_full", 128'(ready_out), 128'd0);
    data_in = blk_c;
    step();
    chk("bp_count_held", 128'(count), 128'd2);
    chk("bp_stall_data", data_out, ref_inv(blk_a));
    ready_in = 1'b1;
    step();  // A popped; C refused because the FIFO was full at this edge
    chk("bp_out_b", data_out, ref_inv(blk_b));
    chk("bp_count_pop", 128'(count), 128'd1);
    step();  // C pushed, B popped
    valid_in = 1'b0;
    chk("bp_out_c", data_out, ref_inv(blk_c));
    chk("bp_count_c", 128'(count), 128'd1);
    step();
    chk("bp_empty", 128'(valid_out), 128'd0);

    // Streaming: one block per clock, occupancy stays at 1.
    ready_in = 1'b1;
    valid_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      data_in = {4{32'(i * 32'h01010101 + 32'h00010203)}};
      step();
      chk($sformatf("stream%0d_data", i),  data_out,        ref_inv(data_in));
      chk($sformatf("stream%0d_count", i), 128'(count),     128'd1);
      chk($sformatf("stream%0d_valid", i), 128'(valid_out), 128'd1);
    end
    valid_in = 1'b0;
    step();
    chk("stream_drain", 128'(count), 128'd0);

    // Reset mid-operation with the FIFO full.
    ready_in = 1'b0;
    valid_in = 1'b1;
    data_in  = blk_a;
    step();
    data_in = blk_b;
    step();
    valid_in = 1'b0;
    chk("mrst_full", 128'(count), 128'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_valid_out", 128'(valid_out), 128'd0);
    chk("mrst_count",     128'(count),     128'd0);
    chk("mrst_data_out",  data_out,        128'd0);
    chk("mrst_ready_out", 128'(ready_out), 128'd1);
    step();
    rst = 1'b1;
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mrst_stale%0d", i), 128'(valid_out), 128'd0);
    end

    // Wrap-around with random downstream stalls against a reference queue.
    sent = 0;
    got  = 0;
    q.delete();
    for (int cyc = 0; cyc < 300 && got < 16; cyc++) begin
      valid_in = (sent < 16);
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      ready_in = 1'($urandom_range(0, 1));
      #1;
      chk("wrap_valid_out", 128'(valid_out), 128'(q.size() != 0));
      if (q.size() != 0) chk("wrap_data", data_out, q[0]);
      push_ok = valid_in && (q.size() != 2);
      pop_ok  = ready_in && (q.size() != 0);
      step();
      if (pop_ok) begin
        void'(q.pop_front());
        got++;
      end
      if (push_ok) begin
        q.push_back(ref_inv(data_in));
        sent++;
      end
      chk("wrap_count", 128'(count), 128'(q.size()));
    end
    valid_in = 1'b0;
    chk("wrap_all_received", 128'(got), 128'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
